// File: rtl/alu_rr_scheduler_pkg.sv
// Shared constants and types for the ALU round-robin scheduler.
package alu_sched_pkg;

  localparam int unsigned NUM_REQ_D   = 4;
  localparam int unsigned WIDTH_D     = 32;
  localparam int unsigned OP_W_D      = 3;
  localparam int unsigned NUM_UNITS_D = 3;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } sched_state_t;

endpackage

// File: rtl/alu_rr_scheduler_if.sv
// Request fan-in and response channel between client engines and the scheduler.
interface alu_rr_scheduler_if import alu_sched_pkg::*; #(
  parameter int unsigned NUM_REQ = NUM_REQ_D,
  parameter int unsigned WIDTH   = WIDTH_D,
  parameter int unsigned OP_W    = OP_W_D,
  parameter int unsigned SEL_W   = $clog2(NUM_UNITS_D) + 1
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0][WIDTH-1:0] req_a;
  logic [NUM_REQ-1:0][WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0][OP_W-1:0]  req_op;
  logic [NUM_REQ-1:0][SEL_W-1:0] req_sel;

  logic                          rsp_valid;
  logic                          rsp_ready;
  logic [WIDTH-1:0]              rsp_data;
  logic [ID_W-1:0]               rsp_id;
  logic                          rsp_err;

  modport master (
    output req_valid, req_a, req_b, req_op, req_sel, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, req_sel, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, rsp_err
  );

endinterface

// File: rtl/alu_rr_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts one past the last accepted winner.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  // prio_q is the index that currently has top priority
  logic [IW-1:0] prio_q;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] hi_idx;
  logic [IW-1:0] lo_idx;
  logic          hi_found;
  logic          lo_found;

  // Lowest requester at/after the pointer wins; otherwise wrap to the lowest requester overall
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_found = 1'b1;
        lo_idx   = IW'(i);
        if (IW'(i) >= prio_q) begin
          hi_found = 1'b1;
          hi_idx   = IW'(i);
        end
      end
    end
    win_idx = hi_found ? hi_idx : lo_idx;
    grant   = '0;
    if (lo_found) grant[win_idx] = 1'b1;
  end

  // Pointer moves only on an accepted handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q <= '0;
    end else if (advance) begin
      prio_q <= (win_idx == IW'(N - 1)) ? '0 : win_idx + 1'b1;
    end
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one ALU between NUM_REQ requesters; one operation in flight, tagged response.
module alu_rr_scheduler import alu_sched_pkg::*; #(
  parameter int unsigned NUM_REQ   = NUM_REQ_D,
  parameter int unsigned WIDTH     = WIDTH_D,
  parameter int unsigned OP_W      = OP_W_D,
  parameter int unsigned NUM_UNITS = NUM_UNITS_D,
  parameter int unsigned SEL_W     = $clog2(NUM_UNITS) + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  alu_rr_scheduler_if.slave            bus,
  output logic [WIDTH-1:0]             alu_a,
  output logic [WIDTH-1:0]             alu_b,
  output logic [OP_W-1:0]              alu_op,
  output logic [$clog2(NUM_UNITS)-1:0] alu_sel,
  input  logic [WIDTH-1:0]             alu_out
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);
  localparam int unsigned UW   = $clog2(NUM_UNITS);

  sched_state_t       state;
  logic [NUM_REQ-1:0] grant;
  logic               can_accept;
  logic               accept;

  logic [ID_W-1:0]    gnt_id;
  logic [WIDTH-1:0]   pick_a;
  logic [WIDTH-1:0]   pick_b;
  logic [OP_W-1:0]    pick_op;
  logic [SEL_W-1:0]   pick_sel;

  logic [ID_W-1:0]    id_q;
  logic               err_q;
  logic               rsp_valid_q;
  logic [WIDTH-1:0]   rsp_data_q;
  logic [ID_W-1:0]    rsp_id_q;
  logic               rsp_err_q;

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (bus.req_valid),
    .advance(accept),
    .grant  (grant)
  );

  // Route the granted requester's payload toward the issue registers
  always_comb begin
    gnt_id   = '0;
    pick_a   = '0;
    pick_b   = '0;
    pick_op  = '0;
    pick_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        gnt_id   = ID_W'(i);
        pick_a   = bus.req_a[i];
        pick_b   = bus.req_b[i];
        pick_op  = bus.req_op[i];
        pick_sel = bus.req_sel[i];
      end
    end
  end

  // A new op may enter while idle, or while the current response is being taken
  assign can_accept    = (state == IDLE) || ((state == RESP) && bus.rsp_ready);
  assign accept        = can_accept && (|grant);
  assign bus.req_ready = {NUM_REQ{can_accept}} & grant;

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_err   = rsp_err_q;

  // Issue/response FSM with registered ALU inputs and response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= '0;
      alu_sel     <= '0;
      id_q        <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      if (accept) begin
        alu_a  <= pick_a;
        alu_b  <= pick_b;
        alu_op <= pick_op;
        id_q   <= gnt_id;
        // Illegal unit selects are steered to unit 0 and flagged
        if (pick_sel >= SEL_W'(NUM_UNITS)) begin
          alu_sel <= '0;
          err_q   <= 1'b1;
        end else begin
          alu_sel <= pick_sel[UW-1:0];
          err_q   <= 1'b0;
        end
      end
      case (state)
        IDLE: begin
          if (accept) state <= EXEC;
        end
        EXEC: begin
          rsp_data_q  <= err_q ? '0 : alu_out;
          rsp_id_q    <= id_q;
          rsp_err_q   <= err_q;
          rsp_valid_q <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= accept ? EXEC : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed and randomized checks for alu_rr_scheduler against a transaction-level model.
module tb_alu_rr_scheduler;
  import alu_sched_pkg::*;

  localparam int unsigned NR = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic [1:0]  alu_sel;
  logic [31:0] alu_out;

  int n_pass   = 0;
  int n_checks = 0;
  int cyc      = 0;

  alu_rr_scheduler_if #(.NUM_REQ(NR), .WIDTH(32), .OP_W(3), .SEL_W(3)) bus ();

  alu_rr_scheduler #(
    .NUM_REQ  (NR),
    .WIDTH    (32),
    .OP_W     (3),
    .NUM_UNITS(3),
    .SEL_W    (3)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .alu_a  (alu_a),
    .alu_b  (alu_b),
    .alu_op (alu_op),
    .alu_sel(alu_sel),
    .alu_out(alu_out)
  );

  always #5 clk = ~clk;

  // ALU under test harness: unit0 add, unit1 xor, unit2 shl
  always_comb begin
    case (alu_sel)
      2'd0:    alu_out = alu_a + alu_b;
      2'd1:    alu_out = alu_a ^ alu_b;
      2'd2:    alu_out = alu_a << alu_b[4:0];
      default: alu_out = '0;
    endcase
  end

  // Expected response for a request, straight from the unit definitions
  function automatic logic [31:0] ref_rsp(input logic [2:0] sel, input logic [31:0] a,
                                          input logic [31:0] b);
    case (sel)
      3'd0:    return a + b;
      3'd1:    return a ^ b;
      3'd2:    return a << b[4:0];
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] sel);
    bus.req_valid[r] = 1'b1;
    bus.req_a[r]     = a;
    bus.req_b[r]     = b;
    bus.req_op[r]    = 3'(r);
    bus.req_sel[r]   = sel;
  endtask

  task automatic do_reset();
    bus.req_valid = '0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [31:0] data;
    int          id;
    logic        err;
    int          cyc;
  } rsp_t;

  rsp_t        q[$];
  bit          pend[NR];
  logic [31:0] pa[NR];
  logic [31:0] pb[NR];
  logic [2:0]  psel[NR];
  int          order[5] = '{0, 1, 2, 3, 0};

  initial begin
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;
    bus.req_sel   = '0;
    bus.rsp_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    // Reset state
    check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_rsp_id", 32'(bus.rsp_id), 0);
    check("rst_rsp_err", 32'(bus.rsp_err), 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_op", 32'(alu_op), 0);
    check("rst_alu_sel", 32'(alu_sel), 0);
    check("rst_req_ready", 32'(bus.req_ready), 0);

    // Single request, latency 2
    set_req(0, 5, 7, 0);
    bus.rsp_ready = 1'b1;
    #1;
    check("t1_ready", 32'(bus.req_ready), 32'b0001);
    step();
    bus.req_valid[0] = 1'b0;
    #1;
    check("t1_exec_valid", 32'(bus.rsp_valid), 0);
    check("t1_alu_a", alu_a, 5);
    check("t1_alu_b", alu_b, 7);
    step();
    #1;
    check("t1_rsp_valid", 32'(bus.rsp_valid), 1);
    check("t1_rsp_data", bus.rsp_data, 12);
    check("t1_rsp_id", 32'(bus.rsp_id), 0);
    check("t1_rsp_err", 32'(bus.rsp_err), 0);
    step();
    #1;
    check("t1_idle_valid", 32'(bus.rsp_valid), 0);

    // All requesters valid: rotation 0,1,2,3,0, one accept every 2 cycles
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, 32'(100 + i), 32'(i + 1), 3'(i % 3));
    for (int k = 0; k < 5; k++) begin
      #1;
      check("t2_grant", 32'(bus.req_ready), 32'(1) << order[k]);
      if (k > 0) begin
        check("t2_rsp_valid", 32'(bus.rsp_valid), 1);
        check("t2_rsp_id", 32'(bus.rsp_id), 32'(order[k-1]));
        check("t2_rsp_data", bus.rsp_data,
              ref_rsp(bus.req_sel[order[k-1]], bus.req_a[order[k-1]], bus.req_b[order[k-1]]));
      end
      step();
      #1;
      check("t2_exec_ready", 32'(bus.req_ready), 0);
      check("t2_exec_valid", 32'(bus.rsp_valid), 0);
      step();
    end

    // Response back-pressure: everything frozen, pointer untouched
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("t3_valid", 32'(bus.rsp_valid), 1);
      check("t3_id", 32'(bus.rsp_id), 0);
      check("t3_data", bus.rsp_data, 32'd101);
      check("t3_ready", 32'(bus.req_ready), 0);
      step();
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("t3_ptr", 32'(bus.req_ready), 32'b0010);
    bus.req_valid = '0;
    step();

    // Illegal unit select
    set_req(2, 1, 1, 3);
    #1;
    check("t4_ready", 32'(bus.req_ready), 32'b0100);
    step();
    bus.req_valid[2] = 1'b0;
    #1;
    check("t4_alu_sel", 32'(alu_sel), 0);
    step();
    #1;
    check("t4_err", 32'(bus.rsp_err), 1);
    check("t4_data", bus.rsp_data, 0);
    check("t4_id", 32'(bus.rsp_id), 2);
    step();

    // Reset while an op is in EXEC
    set_req(1, 9, 9, 0);
    #1;
    check("t5_ready1", 32'(bus.req_ready), 32'b0010);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("t5_rsp_dropped", 32'(bus.rsp_valid), 0);
    set_req(0, 2, 3, 0);
    #1;
    check("t5_ready0", 32'(bus.req_ready), 32'b0001);
    step();
    bus.req_valid = '0;
    step();
    #1;
    check("t5_rsp_id", 32'(bus.rsp_id), 0);
    check("t5_rsp_data", bus.rsp_data, 5);

    // Accept in the RESP cycle: one bubble then the new result
    set_req(3, 3, 4, 2);
    #1;
    check("t6_ready", 32'(bus.req_ready), 32'b1000);
    step();
    bus.req_valid[3] = 1'b0;
    #1;
    check("t6_bubble", 32'(bus.rsp_valid), 0);
    step();
    #1;
    check("t6_valid", 32'(bus.rsp_valid), 1);
    check("t6_data", bus.rsp_data, 48);
    check("t6_id", 32'(bus.rsp_id), 3);
    check("t6_err", 32'(bus.rsp_err), 0);
    step();

    // Randomized traffic against the transaction model
    do_reset();
    begin
      int   last;
      bit   vis;
      bit   pop;
      bit   free;
      int   win;
      int   c2;
      logic [31:0] exp_ready;
      last = NR - 1;
      q.delete();
      for (int r = 0; r < NR; r++) pend[r] = 1'b0;
      for (int c = 0; c < 400; c++) begin
        for (int r = 0; r < NR; r++) begin
          if (!pend[r] && $urandom_range(2) == 0) begin
            pend[r] = 1'b1;
            pa[r]   = $urandom;
            pb[r]   = $urandom;
            psel[r] = 3'($urandom_range(3));
          end
          bus.req_valid[r] = pend[r];
          bus.req_a[r]     = pa[r];
          bus.req_b[r]     = pb[r];
          bus.req_sel[r]   = psel[r];
          bus.req_op[r]    = 3'($urandom);
        end
        bus.rsp_ready = ($urandom_range(3) != 0);
        #1;
        vis = (q.size() > 0) && (cyc >= q[0].cyc + 2);
        check("rnd_rsp_valid", 32'(bus.rsp_valid), 32'(vis));
        if (vis) begin
          check("rnd_rsp_data", bus.rsp_data, q[0].data);
          check("rnd_rsp_id", 32'(bus.rsp_id), 32'(q[0].id));
          check("rnd_rsp_err", 32'(bus.rsp_err), 32'(q[0].err));
        end
        pop  = vis && bus.rsp_ready;
        free = (q.size() == 0) || ((q.size() == 1) && pop);
        win  = -1;
        if (free) begin
          for (int k = 1; k <= NR; k++) begin
            c2 = (last + k) % NR;
            if (pend[c2] && win < 0) win = c2;
          end
        end
        exp_ready = (win >= 0) ? (32'(1) << win) : 32'd0;
        check("rnd_req_ready", 32'(bus.req_ready), exp_ready);
        if (pop) void'(q.pop_front());
        if (win >= 0) begin
          q.push_back('{ref_rsp(psel[win], pa[win], pb[win]), win, psel[win] >= 3, cyc});
          pend[win] = 1'b0;
          last      = win;
        end
        step();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
